rv32i_id_pipe: RTL and testbench
================================

RV32I_ID_PIPE -- requirements
Module: rv32i_id_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width of PC and register data.
REQ-002 SHALL have parameter NOP_IW, default 32'h00000013, meaning the instruction word injected as a bubble.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the bubble counter.
REQ-004 SHALL have ports, one per line:
- clk  in  1  system clock; one clock domain, all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- iw_in  in  32  instruction word from the fetch stage.
- pc_in  in  XLEN  PC from the fetch stage.
- valid_in  in  1  iw_in/pc_in hold a real instruction.
- rs1_data, rs2_data  in  XLEN  read data from the register interface.
- stall_in  in  1  execute stage cannot accept.
- flush_in  in  1  kill the instruction in decode (taken branch).
- ex_wb_reg  in  5  destination register of the instruction now in execute.
- ex_is_load  in  1  the instruction in execute is a load.
- rs1_reg, rs2_reg  out  5  register-interface read addresses (combinational).
- pc_out  out  XLEN  registered PC.
- iw_out  out  32  registered instruction word.
- rs1_data_out, rs2_data_out  out  XLEN  registered operands.
- wb_reg_out  out  5  registered iw[11:7].
- wb_en_out  out  1  registered writeback enable.
- valid_out  out  1  registered valid.
- stall_out  out  1  hold fetch (combinational).
- halted  out  1  EBREAK latched.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.

Function
REQ-005 SHALL drive rs1_reg = iw_in[19:15] and rs2_reg = iw_in[24:20] combinationally at all times.
REQ-006 SHALL have a two-state FSM, RUN and HALT; RUN goes to HALT when EBREAK (iw_in == 32'h00100073, valid_in=1) transfers; HALT exits only on reset.
REQ-007 SHALL apply a per-edge priority for the output register: reset > stall_in (hold all) > flush_in (bubble) > hazard (bubble) > HALT (bubble) > transfer.
REQ-008 SHALL, on a transfer, register pc_in, iw_in, rs1_data, rs2_data, iw_in[11:7] and valid_in, giving 1-cycle latency.
REQ-009 SHALL, on a bubble, set iw_out=NOP_IW, valid_out=0 and wb_en_out=0; pc_out and the operand outputs keep their prior values.
REQ-010 SHALL set wb_en_out=1 on a transfer except for the following, which give 0:
- valid_in=0;
- opcode 0100011 (store);
- opcode 1100011 (branch);
- opcode 1110011 (system);
- iw_in[11:7]==0.
REQ-011 SHALL pass the EBREAK instruction itself downstream once, with wb_en_out=0; every later edge in HALT inserts a bubble.
REQ-012 SHALL drive stall_out = stall_in | hazard | (state==HALT).
REQ-013 SHALL increment bubble_cnt by 1 on each edge where a bubble is inserted for flush, hazard or HALT, and SHALL saturate it at all-ones with no wrap; stall_in holds do not count.
REQ-014 SHALL let flush_in and hazard in the same cycle insert exactly one bubble and one count.
REQ-015 SHALL treat an EBREAK with flush_in=1 as killed: no HALT entry.

Reset
REQ-016 SHALL, on reset, set state=RUN, pc_out=0, iw_out=NOP_IW, rs1_data_out=0, rs2_data_out=0, wb_reg_out=0, wb_en_out=0, valid_out=0 and bubble_cnt=0.
REQ-017 SHALL let reset asserted in HALT or during a stall take effect at the next edge, overriding all other inputs.

Configuration
REQ-018 SHALL, with macro RV32I_ID_HAZARD_EN defined, compute hazard = valid_in & ex_is_load & (ex_wb_reg!=0) & (ex_wb_reg==rs1_reg | ex_wb_reg==rs2_reg).
REQ-019 SHALL, without RV32I_ID_HAZARD_EN, tie hazard to 0 and leave ex_wb_reg and ex_is_load unused.

Verification
REQ-020 SHALL pass a transfer check: iw_in=32'h00500093 (addi x1,x0,5), pc_in=32'h40, valid_in=1 -> next edge iw_out=32'h00500093, pc_out=32'h40, wb_reg_out=1, wb_en_out=1, valid_out=1.
REQ-021 SHALL pass a store check: iw_in=32'h00112023 (sw) -> wb_en_out=0, valid_out=1; then iw_in with rd=x0 -> wb_en_out=0.
REQ-022 SHALL pass a load-use check (HAZARD_EN): ex_is_load=1, ex_wb_reg=5, iw_in rs1=5 -> stall_out=1, iw_out=32'h13, valid_out=0, bubble_cnt 0->1; next cycle ex_is_load=0 -> transfer.
REQ-023 SHALL pass a flush-vs-stall check: stall_in=1 and flush_in=1 together -> outputs held, bubble_cnt unchanged; stall_in=0, flush_in=1 -> bubble, count +1.
REQ-024 SHALL pass an EBREAK check: iw_in=32'h00100073 -> iw_out=32'h00100073, wb_en_out=0, halted=1, stall_out=1; next 3 edges iw_out=32'h13, bubble_cnt +3; reset -> halted=0, all outputs at reset values.
REQ-025 SHALL pass a saturation check: CNT_W=2, 5 flushes -> bubble_cnt=3.

Source files
------------

// File: rtl/rv32i_id_pipe_if.sv
// Decode-stage bus: fetch inputs, register-file read port, execute feedback and decode outputs.
interface rv32i_id_pipe_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic [31:0]      iw_in;
   logic [XLEN-1:0]  pc_in;
   logic             valid_in;
   logic [XLEN-1:0]  rs1_data;
   logic [XLEN-1:0]  rs2_data;
   logic             stall_in;
   logic             flush_in;
   logic [4:0]       ex_wb_reg;
   logic             ex_is_load;
   logic [4:0]       rs1_reg;
   logic [4:0]       rs2_reg;
   logic [XLEN-1:0]  pc_out;
   logic [31:0]      iw_out;
   logic [XLEN-1:0]  rs1_data_out;
   logic [XLEN-1:0]  rs2_data_out;
   logic [4:0]       wb_reg_out;
   logic             wb_en_out;
   logic             valid_out;
   logic             stall_out;
   logic             halted;
   logic [CNT_W-1:0] bubble_cnt;

   modport slave (
      input  iw_in, pc_in, valid_in, rs1_data, rs2_data, stall_in, flush_in,
             ex_wb_reg, ex_is_load,
      output rs1_reg, rs2_reg, pc_out, iw_out, rs1_data_out, rs2_data_out,
             wb_reg_out, wb_en_out, valid_out, stall_out, halted, bubble_cnt
   );

   modport master (
      output iw_in, pc_in, valid_in, rs1_data, rs2_data, stall_in, flush_in,
             ex_wb_reg, ex_is_load,
      input  rs1_reg, rs2_reg, pc_out, iw_out, rs1_data_out, rs2_data_out,
             wb_reg_out, wb_en_out, valid_out, stall_out, halted, bubble_cnt
   );
endinterface

// File: rtl/rv32i_id_pipe.sv
// RV32I decode pipeline register with stall/flush/bubble handling and EBREAK halt.
// Load-use hazard detection is compiled in only when RV32I_ID_HAZARD_EN is defined.
module rv32i_id_pipe #(
   parameter int          XLEN   = 32,
   parameter logic [31:0] NOP_IW = 32'h00000013,
   parameter int          CNT_W  = 16
) (
   input logic            clk,
   input logic            reset,
   rv32i_id_pipe_if.slave bus
);
   localparam logic [31:0] EBREAK_IW = 32'h00100073;

   typedef enum logic {S_RUN, S_HALT} state_t;

   state_t r_state, w_state_nxt;

   logic              w_hazard;
   logic              w_halt;
   logic              w_bubble;
   logic              w_xfer;
   logic              w_stall_out;
   logic [XLEN-1:0]   r_pc_p1;
   logic [31:0]       r_iw_p1;
   logic [XLEN-1:0]   r_rs1_p1;
   logic [XLEN-1:0]   r_rs2_p1;
   logic [4:0]        r_wbr_p1;
   logic              r_wbe_p1;
   logic              vld_p1;
   logic [CNT_W-1:0]  r_bubble_cnt;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   function automatic logic f_wb_en(input logic [31:0] iw, input logic vld);
      logic [6:0] op;
      op = iw[6:0];
      return vld && (op != 7'b0100011) && (op != 7'b1100011) &&
             (op != 7'b1110011) && (iw[11:7] != 5'd0);
   endfunction

   assign bus.rs1_reg = bus.iw_in[19:15];
   assign bus.rs2_reg = bus.iw_in[24:20];

`ifdef RV32I_ID_HAZARD_EN
   assign w_hazard = bus.valid_in & bus.ex_is_load & (bus.ex_wb_reg != 5'd0) &
                     ((bus.ex_wb_reg == bus.iw_in[19:15]) | (bus.ex_wb_reg == bus.iw_in[24:20]));
`else
   logic w_unused_hz;
   assign w_unused_hz = ^{bus.ex_wb_reg, bus.ex_is_load};
   assign w_hazard    = 1'b0;
`endif

   assign w_halt   = (r_state == S_HALT);
   assign w_bubble = !bus.stall_in && (bus.flush_in || w_hazard || w_halt);
   assign w_xfer   = !bus.stall_in && !bus.flush_in && !w_hazard && !w_halt;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   // A killed (flushed) or hazard-blocked EBREAK never reaches the transfer path, so it cannot halt
   always_comb begin
      w_state_nxt = r_state;
      w_stall_out = bus.stall_in | w_hazard | w_halt;
      if (r_state == S_RUN && w_xfer && bus.valid_in && bus.iw_in == EBREAK_IW)
         w_state_nxt = S_HALT;
   end

   // Stage boundary: decode -> execute
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc_p1      <= '0;
         r_iw_p1      <= NOP_IW;
         r_rs1_p1     <= '0;
         r_rs2_p1     <= '0;
         r_wbr_p1     <= '0;
         r_wbe_p1     <= 1'b0;
         vld_p1       <= 1'b0;
         r_bubble_cnt <= '0;
      end else if (bus.stall_in) begin
         r_pc_p1 <= r_pc_p1;
      end else if (w_bubble) begin
         r_iw_p1      <= NOP_IW;
         r_wbe_p1     <= 1'b0;
         vld_p1       <= 1'b0;
         r_bubble_cnt <= f_sat_inc(r_bubble_cnt);
      end else begin
         r_pc_p1  <= bus.pc_in;
         r_iw_p1  <= bus.iw_in;
         r_rs1_p1 <= bus.rs1_data;
         r_rs2_p1 <= bus.rs2_data;
         r_wbr_p1 <= bus.iw_in[11:7];
         r_wbe_p1 <= f_wb_en(bus.iw_in, bus.valid_in);
         vld_p1   <= bus.valid_in;
      end
   end

   assign bus.pc_out       = r_pc_p1;
   assign bus.iw_out       = r_iw_p1;
   assign bus.rs1_data_out = r_rs1_p1;
   assign bus.rs2_data_out = r_rs2_p1;
   assign bus.wb_reg_out   = r_wbr_p1;
   assign bus.wb_en_out    = r_wbe_p1;
   assign bus.valid_out    = vld_p1;
   assign bus.stall_out    = w_stall_out;
   assign bus.halted       = w_halt;
   assign bus.bubble_cnt   = r_bubble_cnt;
endmodule

// File: tb/tb_rv32i_id_pipe.sv
// Directed scoreboard bench for rv32i_id_pipe: a 16-bit counter instance and a 2-bit one.
module tb_rv32i_id_pipe;
   logic clk = 1'b0;
   logic reset, rst2;
   always #5 clk = ~clk;

`ifdef RV32I_ID_HAZARD_EN
   localparam logic HZ = 1'b1;
`else
   localparam logic HZ = 1'b0;
`endif

   rv32i_id_pipe_if #(.XLEN(32), .CNT_W(16)) bus1 ();
   rv32i_id_pipe_if #(.XLEN(32), .CNT_W(2))  bus2 ();

   rv32i_id_pipe #(.XLEN(32), .NOP_IW(32'h00000013), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave));
   rv32i_id_pipe #(.XLEN(32), .NOP_IW(32'h00000013), .CNT_W(2)) dut2 (
      .clk(clk), .reset(rst2), .bus(bus2.slave));

   typedef struct {
      string       tag;
      logic [31:0] iw, pc, d1, d2;
      logic [4:0]  wbr;
      logic        wbe, vld, hlt, stl;
      logic [15:0] cnt;
   } exp_t;

   exp_t        q[$];
   logic [1:0]  q2[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] ec;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] iw, pc, d1, d2,
                       input logic [4:0] wbr, input logic wbe, vld, hlt, stl,
                       input logic [15:0] cnt);
      exp_t e;
      e.tag = tag; e.iw = iw; e.pc = pc; e.d1 = d1; e.d2 = d2; e.wbr = wbr;
      e.wbe = wbe; e.vld = vld; e.hlt = hlt; e.stl = stl; e.cnt = cnt;
      q.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = q.pop_front();
      chk({e.tag, ".iw"},   bus1.iw_out,       e.iw);
      chk({e.tag, ".pc"},   bus1.pc_out,       e.pc);
      chk({e.tag, ".d1"},   bus1.rs1_data_out, e.d1);
      chk({e.tag, ".d2"},   bus1.rs2_data_out, e.d2);
      chk({e.tag, ".wbr"},  {27'd0, bus1.wb_reg_out}, {27'd0, e.wbr});
      chk({e.tag, ".wbe"},  {31'd0, bus1.wb_en_out},  {31'd0, e.wbe});
      chk({e.tag, ".vld"},  {31'd0, bus1.valid_out},  {31'd0, e.vld});
      chk({e.tag, ".hlt"},  {31'd0, bus1.halted},     {31'd0, e.hlt});
      chk({e.tag, ".stl"},  {31'd0, bus1.stall_out},  {31'd0, e.stl});
      chk({e.tag, ".cnt"},  {16'd0, bus1.bubble_cnt}, {16'd0, e.cnt});
      if (q2.size() != 0)
         chk({e.tag, ".cnt2"}, {30'd0, bus2.bubble_cnt}, {30'd0, q2.pop_front()});
   endtask

   task automatic drv(input logic [31:0] iw, pc, input logic vld,
                      input logic [31:0] d1, d2, input logic stl, fl);
      bus1.iw_in = iw; bus1.pc_in = pc; bus1.valid_in = vld;
      bus1.rs1_data = d1; bus1.rs2_data = d2;
      bus1.stall_in = stl; bus1.flush_in = fl;
   endtask

   initial begin
      reset = 1'b1; rst2 = 1'b1;
      drv(32'h13, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      bus1.ex_wb_reg = 5'd0; bus1.ex_is_load = 1'b0;
      bus2.iw_in = 32'h13; bus2.pc_in = 32'h0; bus2.valid_in = 1'b0;
      bus2.rs1_data = 32'h0; bus2.rs2_data = 32'h0; bus2.stall_in = 1'b0;
      bus2.flush_in = 1'b0; bus2.ex_wb_reg = 5'd0; bus2.ex_is_load = 1'b0;
      ec = 16'd0;
      @(posedge clk); #1;

      push("reset", 32'h13, 0, 0, 0, 5'd0, 0, 0, 0, 0, 16'd0);
      q2.push_back(2'd0);
      tick();
      reset = 1'b0; rst2 = 1'b0;

      drv(32'h00500093, 32'h40, 1, 32'h11111111, 32'h22222222, 0, 0);
      #1;
      chk("rs1_reg_addi", {27'd0, bus1.rs1_reg}, 32'd0);
      chk("rs2_reg_addi", {27'd0, bus1.rs2_reg}, 32'd5);
      push("addi", 32'h00500093, 32'h40, 32'h11111111, 32'h22222222, 5'd1, 1, 1, 0, 0, ec);
      tick();

      drv(32'h00112023, 32'h44, 1, 32'h0, 32'h0, 0, 0);
      #1;
      chk("rs1_reg_sw", {27'd0, bus1.rs1_reg}, 32'd2);
      chk("rs2_reg_sw", {27'd0, bus1.rs2_reg}, 32'd1);
      push("store", 32'h00112023, 32'h44, 0, 0, 5'd0, 0, 1, 0, 0, ec);
      tick();

      drv(32'h00500013, 32'h48, 1, 32'h0, 32'h0, 0, 0);
      push("rd_x0", 32'h00500013, 32'h48, 0, 0, 5'd0, 0, 1, 0, 0, ec);
      tick();

      drv(32'h00208463, 32'h4c, 1, 32'h0, 32'h0, 0, 0);
      push("branch", 32'h00208463, 32'h4c, 0, 0, 5'd8, 0, 1, 0, 0, ec);
      tick();

      drv(32'h00500093, 32'h50, 0, 32'h33333333, 32'h44444444, 0, 0);
      push("invalid", 32'h00500093, 32'h50, 32'h33333333, 32'h44444444, 5'd1, 0, 0, 0, 0, ec);
      tick();

      drv(32'h00700113, 32'h54, 1, 32'h55555555, 32'h55555555, 1, 1);
      push("stall_flush", 32'h00500093, 32'h50, 32'h33333333, 32'h44444444, 5'd1, 0, 0, 0, 1, ec);
      tick();

      drv(32'h00700113, 32'h54, 1, 32'h55555555, 32'h55555555, 0, 1);
      ec = ec + 1;
      push("flush", 32'h13, 32'h50, 32'h33333333, 32'h44444444, 5'd1, 0, 0, 0, 0, ec);
      tick();

      bus1.ex_is_load = 1'b1; bus1.ex_wb_reg = 5'd5;
      drv(32'h00128193, 32'h58, 1, 32'h66666666, 32'h77777777, 0, 0);
      #1;
      chk("hazard_stall_out", {31'd0, bus1.stall_out}, {31'd0, HZ});
      if (HZ) begin
         ec = ec + 1;
         push("load_use", 32'h13, 32'h50, 32'h33333333, 32'h44444444, 5'd1, 0, 0, 0, 1, ec);
         tick();
         bus1.ex_is_load = 1'b0;
      end
      push("after_load", 32'h00128193, 32'h58, 32'h66666666, 32'h77777777, 5'd3, 1, 1, 0, 0, ec);
      tick();

      bus1.ex_is_load = 1'b1;
      drv(32'h00128193, 32'h5c, 1, 32'h88888888, 32'h99999999, 0, 1);
      ec = ec + 1;
      push("flush_hazard", 32'h13, 32'h58, 32'h66666666, 32'h77777777, 5'd3, 0, 0, 0, HZ, ec);
      tick();
      bus1.ex_is_load = 1'b0;

      drv(32'h00100073, 32'h60, 1, 32'haaaaaaaa, 32'hbbbbbbbb, 0, 1);
      ec = ec + 1;
      push("ebreak_killed", 32'h13, 32'h58, 32'h66666666, 32'h77777777, 5'd3, 0, 0, 0, 0, ec);
      tick();

      drv(32'h00100073, 32'h60, 1, 32'haaaaaaaa, 32'hbbbbbbbb, 0, 0);
      push("ebreak", 32'h00100073, 32'h60, 32'haaaaaaaa, 32'hbbbbbbbb, 5'd0, 0, 1, 1, 1, ec);
      tick();

      drv(32'h00500093, 32'h64, 1, 32'h12345678, 32'h12345678, 0, 0);
      for (int i = 0; i < 3; i++) begin
         ec = ec + 1;
         push("halt_bubble", 32'h13, 32'h60, 32'haaaaaaaa, 32'hbbbbbbbb, 5'd0, 0, 0, 1, 1, ec);
         tick();
      end

      bus1.stall_in = 1'b1;
      push("halt_stall", 32'h13, 32'h60, 32'haaaaaaaa, 32'hbbbbbbbb, 5'd0, 0, 0, 1, 1, ec);
      tick();

      reset = 1'b1;
      ec = 16'd0;
      push("reset_halt", 32'h13, 0, 0, 0, 5'd0, 0, 0, 0, 1, ec);
      tick();
      reset = 1'b0;

      drv(32'h00500093, 32'h68, 1, 32'hcafef00d, 32'h0badbeef, 0, 0);
      push("post_reset", 32'h00500093, 32'h68, 32'hcafef00d, 32'h0badbeef, 5'd1, 1, 1, 0, 0, ec);
      tick();

      drv(32'h00500093, 32'h6c, 0, 32'hcafef00d, 32'h0badbeef, 1, 0);
      bus2.flush_in = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         push("sat_hold", 32'h00500093, 32'h68, 32'hcafef00d, 32'h0badbeef, 5'd1, 1, 1, 0, 1, ec);
         q2.push_back((i >= 3) ? 2'd3 : 2'(i));
         tick();
      end
      bus2.flush_in = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
